// File: rtl/lane_occupancy_counter.sv
`default_nettype none
// ============================================================================
// lane_occupancy_counter - multi-lane debounced entry/exit counter with
// saturating occupancy, sticky error flags and serial BCD output.  Rev 1.0
// ============================================================================
module lane_occupancy_counter #(
  parameter int NUM_LANES      = 2,
  parameter int CAPACITY       = 99,
  parameter int NUM_DIGITS     = 2,
  parameter int DEBOUNCE_COUNT = 1000000,
  localparam int OCC_W         = $clog2(CAPACITY + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_LANES-1:0]    s1,
  input  logic [NUM_LANES-1:0]    s2,
  input  logic                    clear,
  input  logic                    clear_err,
  output logic [OCC_W-1:0]        occupancy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  output logic                    full,
  output logic                    empty,
  output logic [NUM_LANES-1:0]    lane_in,
  output logic [NUM_LANES-1:0]    lane_out,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int NS       = 2 * NUM_LANES;
  localparam int DB_W     = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam int RAW_W    = OCC_W + 4;
  localparam int BW       = 4 * NUM_DIGITS;
  localparam int STEP_W   = $clog2(OCC_W + 1);
  localparam logic [DB_W-1:0]          DB_LAST   = DB_W'(DEBOUNCE_COUNT - 1);
  localparam logic signed [RAW_W-1:0]  CAP_RAW   = RAW_W'(CAPACITY);
  localparam logic [OCC_W-1:0]         CAP_OCC   = OCC_W'(CAPACITY);
  localparam logic [STEP_W-1:0]        LAST_STEP = STEP_W'(OCC_W - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_IN1, ST_IN2, ST_OUT1, ST_OUT2} lane_state_t;

  logic [NS-1:0]   raw_in, sync1, sync2, deb;
  logic [DB_W-1:0] db_cnt [NS];
  logic [NUM_LANES-1:0] a, b;
  lane_state_t     state [NUM_LANES];

  // Bits [NUM_LANES-1:0] carry the outer sensors, the upper half the inner ones.
  assign raw_in = {s2, s1};
  assign a      = deb[NUM_LANES-1:0];
  assign b      = deb[NS-1:NUM_LANES];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      for (int i = 0; i < NS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_in  <= '0;
      lane_out <= '0;
      for (int i = 0; i < NUM_LANES; i++) state[i] <= ST_IDLE;
    end else begin
      lane_in  <= '0;
      lane_out <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (a[i] && !b[i])      state[i] <= ST_IN1;
            else if (!a[i] && b[i]) state[i] <= ST_OUT1;
          end
          ST_IN1: begin
            if (b[i])       state[i] <= ST_IN2;
            else if (!a[i]) state[i] <= ST_IDLE;
          end
          ST_IN2: begin
            if (!a[i] && !b[i]) begin
              state[i]   <= ST_IDLE;
              lane_in[i] <= 1'b1;
            end else if (a[i] && !b[i]) begin
              state[i] <= ST_IN1;
            end
          end
          ST_OUT1: begin
            if (a[i])       state[i] <= ST_OUT2;
            else if (!b[i]) state[i] <= ST_IDLE;
          end
          ST_OUT2: begin
            if (!a[i] && !b[i]) begin
              state[i]    <= ST_IDLE;
              lane_out[i] <= 1'b1;
            end else if (!a[i] && b[i]) begin
              state[i] <= ST_OUT1;
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  logic [3:0]              n_in, n_out;
  logic signed [RAW_W-1:0] raw;
  logic [OCC_W-1:0]        occ_next;
  logic                    ovf_evt, udf_evt;

  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_in  = n_in  + 4'(lane_in[i]);
      n_out = n_out + 4'(lane_out[i]);
    end
    raw      = $signed({4'b0, occupancy}) + $signed({{OCC_W{1'b0}}, n_in})
             - $signed({{OCC_W{1'b0}}, n_out});
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    occ_next = occupancy;
    if (clear) begin
      occ_next = '0;
    end else if (raw > CAP_RAW) begin
      occ_next = CAP_OCC;
      ovf_evt  = 1'b1;
    end else if (raw[RAW_W-1]) begin
      occ_next = '0;
      udf_evt  = 1'b1;
    end else begin
      occ_next = raw[OCC_W-1:0];
    end
  end

  assign full  = (occupancy == CAP_OCC);
  assign empty = (occupancy == '0);

  logic              busy;
  logic [OCC_W-1:0]  conv_sh;
  logic [BW-1:0]     conv_acc, acc_adj, acc_next;
  logic [STEP_W-1:0] conv_step;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  always_comb begin
    acc_adj = conv_acc;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (conv_acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = conv_acc[4*d +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BW-2:0], conv_sh[OCC_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      busy      <= 1'b0;
      conv_sh   <= '0;
      conv_acc  <= '0;
      conv_step <= '0;
    end else begin
      occupancy <= occ_next;
      overflow  <= clear_err ? ovf_evt : (overflow  | ovf_evt);
      underflow <= clear_err ? udf_evt : (underflow | udf_evt);
      // A new value always restarts the converter, abandoning any run in flight.
      if (occ_next != occupancy) begin
        busy      <= 1'b1;
        bcd_valid <= 1'b0;
        conv_sh   <= occ_next;
        conv_acc  <= '0;
        conv_step <= '0;
      end else if (busy) begin
        conv_acc  <= acc_next;
        conv_sh   <= conv_sh << 1;
        conv_step <= conv_step + 1'b1;
        if (conv_step == LAST_STEP) begin
          busy      <= 1'b0;
          bcd       <= acc_next;
          bcd_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_occupancy_counter.sv
`default_nettype none
// tb_lane_occupancy_counter - table, directed and random lane scripts checked
// against a script-level occupancy model.
module tb_lane_occupancy_counter;
  localparam int NL  = 2;
  localparam int CAP = 99;
  localparam int ND  = 2;
  localparam int DB  = 4;
  localparam int OW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset, clear, clear_err;
  logic [NL-1:0] s1, s2;
  logic [OW-1:0] occupancy;
  logic [4*ND-1:0] bcd;
  logic          bcd_valid, full, empty, overflow, underflow;
  logic [NL-1:0] lane_in, lane_out;

  lane_occupancy_counter #(
    .NUM_LANES(NL), .CAPACITY(CAP), .NUM_DIGITS(ND), .DEBOUNCE_COUNT(DB)
  ) dut (
    .clk(clk), .reset(reset), .s1(s1), .s2(s2), .clear(clear), .clear_err(clear_err),
    .occupancy(occupancy), .bcd(bcd), .bcd_valid(bcd_valid), .full(full), .empty(empty),
    .lane_in(lane_in), .lane_out(lane_out), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Lane scripts: four {s2,s1} steps, step k in bits [2k+1:2k].
  // 0 idle, 1 entry, 2 exit, 3 aborted entry, 4 entry reversal, 5 exit reversal
  logic [7:0] scripts [6] = '{8'h00, 8'h2D, 8'h1E, 8'h01, 8'h1D, 8'h2E};
  int         delta   [6] = '{0, 1, -1, 0, 0, 0};

  int m_occ;
  bit m_ovf, m_udf;

  typedef struct {
    int         k0;
    int         k1;
    bit         cerr;
    int         exp_occ;
    bit         exp_ovf;
    bit         exp_udf;
    logic [7:0] exp_bcd;
  } vec_t;

  vec_t vecs [8];

  function automatic int to_bcd(input int v);
    return ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n, inout int pulses);
    for (int c = 0; c < n; c++) begin
      tick();
      pulses += $countones(lane_in) + $countones(lane_out);
    end
  endtask

  task automatic settle();
    for (int c = 0; c < 40 && !bcd_valid; c++) tick();
    check("bcd_valid settle", int'(bcd_valid), 1);
  endtask

  task automatic check_model(input string tag);
    check({tag, " occupancy"}, int'(occupancy), m_occ);
    check({tag, " overflow"},  int'(overflow),  int'(m_ovf));
    check({tag, " underflow"}, int'(underflow), int'(m_udf));
    check({tag, " full"},      int'(full),      int'(m_occ == CAP));
    check({tag, " empty"},     int'(empty),     int'(m_occ == 0));
    check({tag, " bcd"},       int'(bcd),       to_bcd(m_occ));
  endtask

  task automatic run_round(input int k0, input int k1, input bit cerr, output bit dropped);
    int nin [NL];
    int nout[NL];
    int ks  [NL];
    int raw;
    ks[0] = k0;
    ks[1] = k1;
    dropped = 1'b0;
    for (int ln = 0; ln < NL; ln++) begin
      nin[ln]  = 0;
      nout[ln] = 0;
    end
    for (int st = 0; st < 4; st++) begin
      for (int ln = 0; ln < NL; ln++) begin
        s1[ln] = scripts[ks[ln]][2*st];
        s2[ln] = scripts[ks[ln]][2*st+1];
      end
      if (st == 0 && cerr) clear_err = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        clear_err = 1'b0;
        for (int ln = 0; ln < NL; ln++) begin
          nin[ln]  += int'(lane_in[ln]);
          nout[ln] += int'(lane_out[ln]);
        end
        if (!bcd_valid) dropped = 1'b1;
      end
    end
    for (int c = 0; c < 40 && !bcd_valid; c++) begin
      tick();
      for (int ln = 0; ln < NL; ln++) begin
        nin[ln]  += int'(lane_in[ln]);
        nout[ln] += int'(lane_out[ln]);
      end
    end
    check("bcd_valid settle", int'(bcd_valid), 1);
    if (cerr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    raw = m_occ;
    for (int ln = 0; ln < NL; ln++) raw += delta[ks[ln]];
    if (raw > CAP) begin
      m_occ = CAP;
      m_ovf = 1'b1;
    end else if (raw < 0) begin
      m_occ = 0;
      m_udf = 1'b1;
    end else begin
      m_occ = raw;
    end
    for (int ln = 0; ln < NL; ln++) begin
      check($sformatf("lane_in pulses lane%0d", ln),  nin[ln],  int'(ks[ln] == 1));
      check($sformatf("lane_out pulses lane%0d", ln), nout[ln], int'(ks[ln] == 2));
    end
    check_model("round");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_occ = 0;
    settle();
  endtask

  initial begin
    bit dropped;
    int pulses;

    vecs[0] = '{1, 0, 1'b0, 1, 1'b0, 1'b0, 8'h01};
    vecs[1] = '{1, 1, 1'b0, 3, 1'b0, 1'b0, 8'h03};
    vecs[2] = '{3, 5, 1'b0, 3, 1'b0, 1'b0, 8'h03};
    vecs[3] = '{1, 2, 1'b0, 3, 1'b0, 1'b0, 8'h03};
    vecs[4] = '{2, 2, 1'b0, 1, 1'b0, 1'b0, 8'h01};
    vecs[5] = '{2, 2, 1'b0, 0, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1, 4, 1'b1, 1, 1'b0, 1'b0, 8'h01};
    vecs[7] = '{4, 1, 1'b0, 2, 1'b0, 1'b0, 8'h02};

    reset = 1'b1; clear = 1'b0; clear_err = 1'b0; s1 = '0; s2 = '0;
    m_occ = 0; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset occupancy", int'(occupancy), 0);
    check("reset bcd",       int'(bcd), 0);
    check("reset bcd_valid", int'(bcd_valid), 1);
    check("reset full",      int'(full), 0);
    check("reset empty",     int'(empty), 1);
    check("reset lane_in",   int'(lane_in), 0);
    check("reset lane_out",  int'(lane_out), 0);
    check("reset overflow",  int'(overflow), 0);
    check("reset underflow", int'(underflow), 0);

    foreach (vecs[i]) begin
      run_round(vecs[i].k0, vecs[i].k1, vecs[i].cerr, dropped);
      check($sformatf("vec%0d occupancy", i), int'(occupancy), vecs[i].exp_occ);
      check($sformatf("vec%0d overflow", i),  int'(overflow),  int'(vecs[i].exp_ovf));
      check($sformatf("vec%0d underflow", i), int'(underflow), int'(vecs[i].exp_udf));
      check($sformatf("vec%0d bcd", i),       int'(bcd),       int'(vecs[i].exp_bcd));
    end

    // Short glitch, then a held entry attempt that is abandoned.
    pulses = 0;
    s1[0] = 1'b1;
    watch(2, pulses);
    s1[0] = 1'b0;
    watch(10, pulses);
    s1[0] = 1'b1;
    watch(10, pulses);
    s1[0] = 1'b0;
    watch(10, pulses);
    check("glitch pulses", pulses, 0);
    check("glitch occupancy", int'(occupancy), m_occ);

    for (int r = 0; r < 30; r++) begin
      run_round(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0), dropped);
    end

    // Climb to 98, then a double entry saturates at capacity.
    do_clear();
    run_round(1, 1, 1'b1, dropped);
    for (int r = 0; r < 48; r++) run_round(1, 1, 1'b0, dropped);
    check("pre-full occupancy", int'(occupancy), 98);
    run_round(1, 1, 1'b0, dropped);
    check("sat occupancy", int'(occupancy), 99);
    check("sat full", int'(full), 1);
    check("sat overflow", int'(overflow), 1);
    check("sat bcd", int'(bcd), 8'h99);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check("clear_err overflow", int'(overflow), 0);
    check("clear_err occupancy", int'(occupancy), 99);

    // Entry and exit in the same cycle net out with no conversion restart.
    do_clear();
    run_round(1, 1, 1'b1, dropped);
    run_round(1, 1, 1'b0, dropped);
    run_round(1, 0, 1'b0, dropped);
    run_round(1, 2, 1'b0, dropped);
    check("net occupancy", int'(occupancy), 5);
    check("net no bcd restart", int'(dropped), 0);

    do_clear();
    run_round(0, 2, 1'b0, dropped);
    check("underflow flag", int'(underflow), 1);
    check("underflow empty", int'(empty), 1);

    // Reset two cycles into the conversion of 37.
    do_clear();
    run_round(1, 1, 1'b1, dropped);
    for (int r = 0; r < 17; r++) run_round(1, 1, 1'b0, dropped);
    for (int st = 0; st < 3; st++) begin
      s1[0] = scripts[1][2*st];
      s2[0] = scripts[1][2*st+1];
      repeat (10) tick();
    end
    s1[0] = 1'b0;
    s2[0] = 1'b0;
    for (int c = 0; c < 20 && bcd_valid; c++) tick();
    check("conv started", int'(bcd_valid), 0);
    check("conv occupancy", int'(occupancy), 37);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_occ = 0; m_ovf = 1'b0; m_udf = 1'b0;
    check("midreset occupancy", int'(occupancy), 0);
    check("midreset bcd",       int'(bcd), 0);
    check("midreset bcd_valid", int'(bcd_valid), 1);
    check("midreset empty",     int'(empty), 1);
    check("midreset full",      int'(full), 0);
    check("midreset pulses",    int'({lane_in, lane_out}), 0);
    check("midreset flags",     int'({overflow, underflow}), 0);
    pulses = 0;
    clear = 1'b1;
    watch(1, pulses);
    clear = 1'b0;
    watch(20, pulses);
    check("post-reset clear pulses", pulses, 0);
    check_model("post-reset clear");
    check("post-reset bcd_valid", int'(bcd_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
